// File: rtl/cnn_addr_pkg.sv
// Shared definitions for the CNN feature-map address generators: sweep state
// encoding, output-dimension helper and per-layer geometry.
package cnn_addr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    int img_w;
    int img_h;
    int k;
    int stride;
    int channels;
  } layer_geom_t;

  localparam layer_geom_t CONV1 = '{img_w: 28, img_h: 28, k: 5, stride: 1, channels: 1};
  localparam layer_geom_t POOL1 = '{img_w: 24, img_h: 24, k: 2, stride: 2, channels: 1};
  localparam layer_geom_t CONV2 = '{img_w: 12, img_h: 12, k: 5, stride: 1, channels: 2};
  localparam layer_geom_t POOL2 = '{img_w: 8,  img_h: 8,  k: 2, stride: 2, channels: 2};

  function automatic int out_dim(input int img, input int k, input int stride);
    return (img - k) / stride + 1;
  endfunction

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/window_addr_gen_if.sv
// Address beat bus from the window address generator to a MAC/pool datapath.
interface window_addr_gen_if #(
  parameter int ADDR_W = 10,
  parameter int KIDX_W = 5,
  parameter int CH_W   = 1
);
  // A beat transfers on a rising edge where addr_valid and addr_ready are both
  // high. addr_valid never depends on addr_ready, and while addr_valid is high
  // without addr_ready the payload (addr, k_idx, ch, flags) holds stable.
  logic              addr_valid;
  logic              addr_ready;
  logic [ADDR_W-1:0] addr;
  logic [KIDX_W-1:0] k_idx;
  logic [CH_W-1:0]   ch;
  logic              win_first;
  logic              win_last;
  logic              last;

  modport master (
    output addr_valid, addr, k_idx, ch, win_first, win_last, last,
    input  addr_ready
  );

  modport slave (
    input  addr_valid, addr, k_idx, ch, win_first, win_last, last,
    output addr_ready
  );
endinterface

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter; o_wrap flags the increment that returns it to zero
// so counters can be chained into a nested loop.
module wrap_counter #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_value,
  output logic         o_wrap
);

  logic [W-1:0] r_value;

  assign o_wrap  = i_inc && (r_value == W'(MAX));
  assign o_value = r_value;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_value <= '0;
    end else if (i_inc) begin
      r_value <= o_wrap ? '0 : r_value + 1'b1;
    end
  end

endmodule

// File: rtl/window_addr_gen.sv
// Sweeps a KxK window over every output position of a multi-channel row-major
// feature map, emitting one read address plus weight index and framing per beat.
module window_addr_gen
  import cnn_addr_pkg::*;
#(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int K         = 5,
  parameter int STRIDE    = 1,
  parameter int CHANNELS  = 1,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state,
  window_addr_gen_if.master bus
);

  localparam int OUT_W  = out_dim(IMG_W, K, STRIDE);
  localparam int OUT_H  = out_dim(IMG_H, K, STRIDE);
  localparam int KC_W   = cnt_w(K);
  localparam int OC_W   = cnt_w(OUT_W);
  localparam int OR_W   = cnt_w(OUT_H);
  localparam int CH_W   = $clog2(CHANNELS) + 1;
  localparam int KIDX_W = cnt_w(K * K);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_DONE = ST_DONE;

  // Address deltas from the last beat of one loop level to the first beat of
  // the next; the channel step is +1 because maps are stored back-to-back.
  localparam int D_KR   = IMG_W - (K - 1);
  localparam int D_OCOL = STRIDE - (K - 1) * IMG_W - (K - 1);
  localparam int D_OROW = STRIDE * IMG_W - (K - 1) * IMG_W - (OUT_W - 1) * STRIDE - (K - 1);

  localparam logic [ADDR_W-1:0] BASE_V    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] STEP_KR   = ADDR_W'(D_KR);
  localparam logic [ADDR_W-1:0] STEP_OCOL = ADDR_W'(D_OCOL);
  localparam logic [ADDR_W-1:0] STEP_OROW = ADDR_W'(D_OROW);

  localparam logic [KC_W-1:0] KC_MAX = KC_W'(K - 1);
  localparam logic [KC_W-1:0] KC_PEN = KC_W'(K - 2);
  localparam logic [OC_W-1:0] OC_MAX = OC_W'(OUT_W - 1);
  localparam logic [OR_W-1:0] OR_MAX = OR_W'(OUT_H - 1);
  localparam logic [CH_W-1:0] CH_MAX = CH_W'(CHANNELS - 1);

  if (K < 2) begin : g_err_k
    $error("window_addr_gen: K must be at least 2");
  end
  if ((IMG_W - K) % STRIDE != 0) begin : g_err_w
    $error("window_addr_gen: (IMG_W-K) not a multiple of STRIDE");
  end
  if ((IMG_H - K) % STRIDE != 0) begin : g_err_h
    $error("window_addr_gen: (IMG_H-K) not a multiple of STRIDE");
  end
  if (longint'(BASE_ADDR) + longint'(CHANNELS) * IMG_W * IMG_H > (longint'(1) << ADDR_W)) begin : g_err_a
    $error("window_addr_gen: feature maps do not fit in ADDR_W");
  end

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [KIDX_W-1:0] r_k_idx;
  logic              r_win_first;
  logic              r_win_last;
  logic              r_last;

  logic              w_load;
  logic              w_clr;
  logic              w_accept;
  logic [KC_W-1:0]   w_kc;
  logic [KC_W-1:0]   w_kr;
  logic [OC_W-1:0]   w_ocol;
  logic [OR_W-1:0]   w_orow;
  logic [CH_W-1:0]   w_ch;
  logic              w_kc_wrap;
  logic              w_kr_wrap;
  logic              w_ocol_wrap;
  logic              w_orow_wrap;
  logic              w_ch_wrap;
  logic [ADDR_W-1:0] w_step;
  logic              w_win_last_nxt;
  logic              w_last_nxt;

  assign w_load   = (r_state == S_IDLE) && start;
  assign w_clr    = reset || w_load;
  assign w_accept = (r_state == S_RUN) && bus.addr_ready;

  wrap_counter #(.MAX(K - 1),        .W(KC_W)) u_kc (
    .i_clk(clk), .i_clr(w_clr), .i_inc(w_accept),    .o_value(w_kc),   .o_wrap(w_kc_wrap));
  wrap_counter #(.MAX(K - 1),        .W(KC_W)) u_kr (
    .i_clk(clk), .i_clr(w_clr), .i_inc(w_kc_wrap),   .o_value(w_kr),   .o_wrap(w_kr_wrap));
  wrap_counter #(.MAX(OUT_W - 1),    .W(OC_W)) u_ocol (
    .i_clk(clk), .i_clr(w_clr), .i_inc(w_kr_wrap),   .o_value(w_ocol), .o_wrap(w_ocol_wrap));
  wrap_counter #(.MAX(OUT_H - 1),    .W(OR_W)) u_orow (
    .i_clk(clk), .i_clr(w_clr), .i_inc(w_ocol_wrap), .o_value(w_orow), .o_wrap(w_orow_wrap));
  wrap_counter #(.MAX(CHANNELS - 1), .W(CH_W)) u_ch (
    .i_clk(clk), .i_clr(w_clr), .i_inc(w_orow_wrap), .o_value(w_ch),   .o_wrap(w_ch_wrap));

  always_comb begin
    w_step = STEP_ONE;
    if (w_orow_wrap) begin
      w_step = STEP_ONE;
    end else if (w_ocol_wrap) begin
      w_step = STEP_OROW;
    end else if (w_kr_wrap) begin
      w_step = STEP_OCOL;
    end else if (w_kc_wrap) begin
      w_step = STEP_KR;
    end
  end

  // Flags are registered, so they are derived from the beat about to follow
  // the current one: win_last next means kc is one short of the end on the last row.
  assign w_win_last_nxt = !w_kc_wrap && (w_kc == KC_PEN) && (w_kr == KC_MAX);
  assign w_last_nxt     = w_win_last_nxt && (w_ocol == OC_MAX) &&
                          (w_orow == OR_MAX) && (w_ch == CH_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= BASE_V;
      r_k_idx     <= '0;
      r_win_first <= 1'b0;
      r_win_last  <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_addr      <= BASE_V;
            r_k_idx     <= '0;
            r_win_first <= 1'b1;
            r_win_last  <= 1'b0;
            r_last      <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (w_ch_wrap) begin
              r_state     <= S_DONE;
              r_addr      <= BASE_V;
              r_k_idx     <= '0;
              r_win_first <= 1'b0;
              r_win_last  <= 1'b0;
              r_last      <= 1'b0;
            end else begin
              r_addr      <= r_addr + w_step;
              r_k_idx     <= w_kr_wrap ? '0 : r_k_idx + 1'b1;
              r_win_first <= w_kr_wrap;
              r_win_last  <= w_win_last_nxt;
              r_last      <= w_last_nxt;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy           = (r_state == S_RUN);
  assign done           = (r_state == S_DONE);
  assign dbg_state      = r_state;
  assign bus.addr_valid = (r_state == S_RUN);
  assign bus.addr       = r_addr;
  assign bus.k_idx      = r_k_idx;
  assign bus.ch         = w_ch;
  assign bus.win_first  = r_win_first;
  assign bus.win_last   = r_win_last;
  assign bus.last       = r_last;

endmodule

// File: tb/tb_window_addr_gen.sv
// Bench for window_addr_gen: three layer geometries, randomized ready, checked
// against a nested-loop reference sweep.
module tb_window_addr_gen;
  import cnn_addr_pkg::*;

  localparam int W = 32;

  logic clk;
  logic reset;
  logic start;
  logic ready;
  int   sel;

  int n_checks;
  int n_fail;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] acc_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  window_addr_gen_if #(.ADDR_W(10), .KIDX_W(5), .CH_W(1)) if_c1 ();
  window_addr_gen_if #(.ADDR_W(10), .KIDX_W(2), .CH_W(1)) if_p1 ();
  window_addr_gen_if #(.ADDR_W(10), .KIDX_W(5), .CH_W(2)) if_c2 ();

  logic c1_busy, c1_done, p1_busy, p1_done, c2_busy, c2_done;
  logic [1:0] c1_state, p1_state, c2_state;

  assign if_c1.addr_ready = ready && (sel == 0);
  assign if_p1.addr_ready = ready && (sel == 1);
  assign if_c2.addr_ready = ready && (sel == 2);

  window_addr_gen #(
    .IMG_W(CONV1.img_w), .IMG_H(CONV1.img_h), .K(CONV1.k), .STRIDE(CONV1.stride),
    .CHANNELS(CONV1.channels), .BASE_ADDR(0), .ADDR_W(10)
  ) u_c1 (
    .clk(clk), .reset(reset), .start(start && (sel == 0)), .busy(c1_busy),
    .done(c1_done), .dbg_state(c1_state), .bus(if_c1)
  );

  window_addr_gen #(
    .IMG_W(POOL1.img_w), .IMG_H(POOL1.img_h), .K(POOL1.k), .STRIDE(POOL1.stride),
    .CHANNELS(POOL1.channels), .BASE_ADDR(0), .ADDR_W(10)
  ) u_p1 (
    .clk(clk), .reset(reset), .start(start && (sel == 1)), .busy(p1_busy),
    .done(p1_done), .dbg_state(p1_state), .bus(if_p1)
  );

  window_addr_gen #(
    .IMG_W(CONV2.img_w), .IMG_H(CONV2.img_h), .K(CONV2.k), .STRIDE(CONV2.stride),
    .CHANNELS(CONV2.channels), .BASE_ADDR(0), .ADDR_W(10)
  ) u_c2 (
    .clk(clk), .reset(reset), .start(start && (sel == 2)), .busy(c2_busy),
    .done(c2_done), .dbg_state(c2_state), .bus(if_c2)
  );

  // Monitor mux: the instance under test is chosen by sel.
  logic       m_valid, m_busy, m_done, m_wf, m_wl, m_last;
  logic [9:0] m_addr;
  logic [7:0] m_kidx, m_ch;
  logic [1:0] m_state;
  logic [W-1:0] m_beat;

  always_comb begin
    m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_wf = 1'b0; m_wl = 1'b0;
    m_last = 1'b0; m_addr = '0; m_kidx = '0; m_ch = '0; m_state = '0;
    case (sel)
      0: begin
        m_valid = if_c1.addr_valid; m_busy = c1_busy; m_done = c1_done;
        m_wf = if_c1.win_first; m_wl = if_c1.win_last; m_last = if_c1.last;
        m_addr = if_c1.addr; m_kidx = 8'(if_c1.k_idx); m_ch = 8'(if_c1.ch); m_state = c1_state;
      end
      1: begin
        m_valid = if_p1.addr_valid; m_busy = p1_busy; m_done = p1_done;
        m_wf = if_p1.win_first; m_wl = if_p1.win_last; m_last = if_p1.last;
        m_addr = if_p1.addr; m_kidx = 8'(if_p1.k_idx); m_ch = 8'(if_p1.ch); m_state = p1_state;
      end
      default: begin
        m_valid = if_c2.addr_valid; m_busy = c2_busy; m_done = c2_done;
        m_wf = if_c2.win_first; m_wl = if_c2.win_last; m_last = if_c2.last;
        m_addr = if_c2.addr; m_kidx = 8'(if_c2.k_idx); m_ch = 8'(if_c2.ch); m_state = c2_state;
      end
    endcase
  end

  function automatic logic [W-1:0] pack_beat(input logic [9:0] a, input logic [7:0] k,
                                             input logic [7:0] c, input logic wf,
                                             input logic wl, input logic ls);
    return {3'b000, ls, wl, wf, c, k, a};
  endfunction

  assign m_beat = pack_beat(m_addr, m_kidx, m_ch, m_wf, m_wl, m_last);

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference sweep straight from the addressing formula.
  task automatic build_model(input layer_geom_t g, output int total);
    int ow, oh, n;
    ow = (g.img_w - g.k) / g.stride + 1;
    oh = (g.img_h - g.k) / g.stride + 1;
    total = g.channels * oh * ow * g.k * g.k;
    n = 0;
    exp_q.delete();
    for (int c = 0; c < g.channels; c++)
      for (int orow = 0; orow < oh; orow++)
        for (int ocol = 0; ocol < ow; ocol++)
          for (int kr = 0; kr < g.k; kr++)
            for (int kc = 0; kc < g.k; kc++) begin
              int a;
              n++;
              a = c * g.img_w * g.img_h + (orow * g.stride + kr) * g.img_w + ocol * g.stride + kc;
              exp_q.push_back(pack_beat(10'(a), 8'(kr * g.k + kc), 8'(c),
                                        (kr == 0) && (kc == 0),
                                        (kr == g.k - 1) && (kc == g.k - 1), n == total));
            end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, m_valid, 1'b0);
    check({tag, "_busy"},  m_busy,  1'b0);
    check({tag, "_done"},  m_done,  1'b0);
    check({tag, "_state"}, m_state, 2'd0);
    check({tag, "_beat"},  m_beat,  pack_beat(10'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic check_acc(input string tag, input int idx, input logic [W-1:0] exp, input logic [W-1:0] mask);
    if (idx < acc_q.size()) check(tag, acc_q[idx] & mask, exp);
    else check({tag, "_missing"}, acc_q.size(), idx + 1);
  endtask

  task automatic run_sweep(input string tag, input int total, input int ready_pct,
                           input bit hold_start, input bit stall_at2, input int abort_at);
    int cyc, nacc, last_acc, stall_left, budget, extra_done;
    bit stalled, prev_hold, got_done, any_valid;
    logic [W-1:0] held;
    cyc = 0; nacc = 0; last_acc = -2; stall_left = 0; stalled = 0;
    prev_hold = 0; got_done = 0; held = '0;
    budget = 4 * total + 200;
    acc_q.delete();
    @(negedge clk);
    start = 1'b1; ready = 1'b0;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    check({tag, "_start_valid"}, m_valid, 1'b1);
    check({tag, "_start_busy"},  m_busy,  1'b1);
    check({tag, "_start_addr"},  m_addr,  10'd0);
    check({tag, "_start_wf"},    m_wf,    1'b1);
    while (cyc < budget && !got_done) begin
      if (m_done) begin
        got_done = 1;
        check({tag, "_done_lat"},   cyc, last_acc + 1);
        check({tag, "_done_valid"}, m_valid, 1'b0);
        start = 1'b0; ready = 1'b0;
      end else begin
        if (prev_hold) check({tag, "_hold"}, m_beat, held);
        if (stall_at2 && !stalled && m_valid && m_addr == 10'd2) begin
          stalled = 1; stall_left = 3;
        end
        if (stall_left > 0) begin
          ready = 1'b0; stall_left--;
        end else begin
          ready = ($urandom_range(99) < ready_pct);
        end
        prev_hold = m_valid && !ready;
        held = m_beat;
        if (m_valid && ready) begin
          if (exp_q.size() > 0) check({tag, "_beat"}, m_beat, exp_q.pop_front());
          else check({tag, "_extra_beat"}, nacc + 1, total);
          acc_q.push_back(m_beat);
          nacc++;
          last_acc = cyc;
          if (abort_at > 0 && nacc == abort_at) begin
            @(negedge clk);
            return;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "_done_seen"}, got_done, 1'b1);
    check({tag, "_beats"}, nacc, total);
    check({tag, "_q_empty"}, exp_q.size(), 0);
    extra_done = 0; any_valid = 0;
    repeat (4) begin
      @(negedge clk);
      if (m_done) extra_done++;
      if (m_valid) any_valid = 1;
    end
    check({tag, "_one_done"}, extra_done, 0);
    check({tag, "_idle_quiet"}, any_valid, 1'b0);
    check({tag, "_idle_state"}, m_state, 2'd0);
  endtask

  localparam logic [W-1:0] ADDR_MASK = 32'h3FF;
  localparam logic [W-1:0] FULL_MASK = 32'hFFFF_FFFF;

  initial begin
    int total, dcnt;
    logic [9:0] c1_first[7];
    logic [9:0] p1_first[8];
    c1_first = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd28, 10'd29};
    p1_first = '{10'd0, 10'd1, 10'd24, 10'd25, 10'd2, 10'd3, 10'd26, 10'd27};
    n_checks = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; ready = 1'b0; sel = 0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_reset_state("rst_init");
    end
    sel = 0;
    @(negedge clk);
    reset = 1'b0;

    // conv1: full sweep, 3-cycle stall at addr 2, random back-pressure after.
    build_model(CONV1, total);
    run_sweep("c1", total, 80, 1'b0, 1'b1, 0);
    for (int i = 0; i < 7; i++) check_acc("c1_first", i, 32'(c1_first[i]), ADDR_MASK);
    check_acc("c1_win2", 25, 32'd1, ADDR_MASK);
    check_acc("c1_final", 14399, pack_beat(10'd783, 8'd24, 8'd0, 1'b0, 1'b1, 1'b1), FULL_MASK);

    // conv1: reset at beat 100 discards the sweep, then a fresh start.
    build_model(CONV1, total);
    run_sweep("c1_abort", total, 100, 1'b0, 1'b0, 100);
    reset = 1'b1; ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("rst_mid");
    dcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (m_done) dcnt++;
    end
    check("rst_mid_no_done", dcnt, 0);
    build_model(CONV1, total);
    run_sweep("c1_restart", total, 100, 1'b0, 1'b0, 10);
    reset = 1'b1; ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // pool1: start held through the sweep and DONE cycle.
    sel = 1;
    build_model(POOL1, total);
    run_sweep("p1", total, 70, 1'b1, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      check_acc("p1_first", i, 32'(p1_first[i]), ADDR_MASK);
      check_acc("p1_wl", i, (i % 4 == 3) ? 32'h0800_0000 : 32'h0, 32'h0800_0000);
    end
    check_acc("p1_final", 575, 32'd575, ADDR_MASK);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("p1_restart_valid", m_valid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // conv2: two channels stored back-to-back.
    sel = 2;
    build_model(CONV2, total);
    run_sweep("c2", total, 75, 1'b0, 1'b0, 0);
    check_acc("c2_ch1_first", 1600, pack_beat(10'd144, 8'd0, 8'd1, 1'b1, 1'b0, 1'b0), FULL_MASK);
    check_acc("c2_final", 3199, 32'd287, ADDR_MASK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
